// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a first-word-fall-through byte FIFO (valid/ready head).
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre instead of one sample.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_serial,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [7:0]                  rx_data,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int unsigned TICK_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIV       = (CLOCK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int unsigned TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW        = $clog2(OVERSAMPLE);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned START_LAST = OVERSAMPLE / 2;
`else
  localparam int unsigned START_LAST = OVERSAMPLE / 2 - 1;
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx_fifo: FIFO_DEPTH (%0d) must be a power of two >= 2", FIFO_DEPTH);
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_rx_fifo: OVERSAMPLE (%0d) must be even and >= 8", OVERSAMPLE);
  end
  if (DIV < 2) begin : g_div_check
    $error("uart_rx_fifo: clock too slow for BAUD_RATE*OVERSAMPLE");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // Input synchronizer plus one extra stage for falling-edge detection.
  logic sync1_reg, rxs, rxs_prev, rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      rxs       <= 1'b1;
      rxs_prev  <= 1'b1;
    end else begin
      sync1_reg <= rx_serial;
      rxs       <= sync1_reg;
      rxs_prev  <= rxs;
    end
  end

  assign rx_fall = rxs_prev & ~rxs;

  logic [TW-1:0] tick_cnt_reg;
  logic          tick, tick_clr;

  assign tick = (tick_cnt_reg == TW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt_reg <= '0;
    else if (tick_clr || tick) tick_cnt_reg <= '0;
    else                       tick_cnt_reg <= tick_cnt_reg + TW'(1);
  end

  state_t        state_reg, state_next;
  logic [SW-1:0] samp_reg, samp_next, last;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          push_reg, push_next, ferr_next, bit_val;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]    vote_reg, vote_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      samp_reg  <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      push_reg  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      samp_reg  <= samp_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      push_reg  <= push_next;
      frame_err <= ferr_next;
`ifdef UART_RX_MAJORITY_EN
      vote_reg  <= vote_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    samp_next  = samp_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    push_next  = 1'b0;
    ferr_next  = 1'b0;
    tick_clr   = 1'b0;
    // The start bit is decided half a bit in; every later bit a full bit after the previous decision.
    last       = (state_reg == START) ? SW'(START_LAST) : SW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    vote_next = vote_reg;
    if (tick && (state_reg inside {START, DATA, STOP})) begin
      if (samp_reg == last - SW'(2)) vote_next[0] = rxs;
      if (samp_reg == last - SW'(1)) vote_next[1] = rxs;
    end
    bit_val = (vote_reg[0] & vote_reg[1]) | (rxs & (vote_reg[0] | vote_reg[1]));
`else
    bit_val = rxs;
`endif

    if (tick && (state_reg inside {START, DATA, STOP}))
      samp_next = (samp_reg == last) ? '0 : samp_reg + SW'(1);

    case (state_reg)
      IDLE: begin
        if (rx_fall) begin
          state_next = START;
          samp_next  = '0;
          tick_clr   = 1'b1;
        end
      end
      START: begin
        if (tick && samp_reg == last) begin
          state_next = bit_val ? IDLE : DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (tick && samp_reg == last) begin
          shift_next[idx_reg] = bit_val;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      STOP: begin
        if (tick && samp_reg == last) begin
          if (bit_val) begin
            push_next  = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The push is applied one cycle after the stop decision so full/pop are judged at write time.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic          pop, full, push_ok;

  assign full    = (cnt_reg == CW'(FIFO_DEPTH));
  assign pop     = (cnt_reg != '0) && rx_ready;
  assign push_ok = push_reg && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push_reg && full && !pop;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign rx_valid = (cnt_reg != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr_reg] : 8'h00;
  assign fifo_cnt = cnt_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table, hand-written corner sequences, random frames vs a queue model.
module tb_uart_rx_fifo;
  localparam int unsigned TB_CLK = 25_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned OS     = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int D = int'((TB_CLK + (BAUD * OS) / 2) / (BAUD * OS));
  localparam int B = D * int'(OS);
`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT_MAX    = (B * 19) / 2 + 4 + D;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int         LAT_MAX    = (B * 19) / 2 + 4;
  localparam logic [7:0] GLITCH_EXP = 8'hF7;
`endif

  logic       clk, rst_n, rx_serial, rx_valid, rx_ready, frame_err, overrun;
  logic [7:0] rx_data;
  logic [$clog2(DEPTH):0] fifo_cnt;

  uart_rx_fifo #(
    .CLOCK_FREQ(TB_CLK), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_data(rx_data), .frame_err(frame_err),
    .overrun(overrun), .fifo_cnt(fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int pc = 0;
  always @(posedge clk) pc <= pc + 1;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int   ferr_cnt = 0, ovr_cnt = 0, valid_cyc = 0, rise_pc = 0, peak = 0;
  int   mark = 0, mark_seen = 0;
  logic prev_valid = 1'b0, hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin
    if (mark != mark_seen) begin
      mark_seen = mark;
      peak      = 0;
    end
    if (!rst_n) begin
      hold_pend  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", int'(rx_valid), 1);
        check("hold_data", int'(rx_data), int'(hold_data));
      end
      hold_pend = rx_valid && !rx_ready;
      hold_data = rx_data;
      if (rx_valid && !prev_valid) rise_pc = pc;
      prev_valid = rx_valid;
      if (rx_valid) valid_cyc++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
    end
  end

  int drive_pc = 0;

  task automatic line(input logic v, input int n);
    rx_serial = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // gbit >= 0 puts a one-tick low pulse centred on that (high) data bit.
  task automatic send(input logic [7:0] d, input logic stop, input int gbit);
    drive_pc = pc;
    line(1'b0, B);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        line(1'b1, B / 2 - D / 2);
        line(1'b0, D);
        line(1'b1, B - B / 2 - D / 2);
      end else begin
        line(d[i], B);
      end
    end
    line(stop, B);
  endtask

  typedef struct {
    int         kind;     // 0 = frame, 1 = short low runt
    logic [7:0] data;
    logic       stop;
    int         gbit;
    int         exp_pops;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] exp_q[$];
  logic [7:0] d;
  logic       s;
  int         base_q, base_ferr, base_ovr, base_vc, exp_ferr, rand_mode;

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b1, -1, 1, 8'hA5, 0};
    tbl[1] = '{1, 8'h00, 1'b1, -1, 0, 8'h00, 0};
    tbl[2] = '{0, 8'h3C, 1'b1, -1, 1, 8'h3C, 0};
    tbl[3] = '{0, 8'h3C, 1'b0, -1, 0, 8'h00, 1};
    tbl[4] = '{0, 8'h81, 1'b1, -1, 1, 8'h81, 0};
    tbl[5] = '{0, 8'hFF, 1'b1,  3, 1, GLITCH_EXP, 0};

    rx_serial = 1'b1;
    rx_ready  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_cnt", int'(fifo_cnt), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    line(1'b1, B);

    for (int k = 0; k < 6; k++) begin
      base_q = got_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt; base_vc = valid_cyc;
      mark++;
      if (tbl[k].kind == 1) begin
        line(1'b0, 3 * D);
        line(1'b1, B);
      end else begin
        send(tbl[k].data, tbl[k].stop, tbl[k].gbit);
      end
      line(1'b1, 2 * B);
      $display("vec %0d: data 0x%02h stop %0d -> %0d byte(s), %0d frame_err cycle(s)",
               k, tbl[k].data, tbl[k].stop, got_q.size() - base_q, ferr_cnt - base_ferr);
      check($sformatf("v%0d_pops", k), got_q.size() - base_q, tbl[k].exp_pops);
      if (tbl[k].exp_pops > 0 && got_q.size() > base_q)
        check($sformatf("v%0d_data", k), int'(got_q[base_q]), int'(tbl[k].exp_data));
      check($sformatf("v%0d_valid_cycles", k), valid_cyc - base_vc, tbl[k].exp_pops);
      check($sformatf("v%0d_ferr", k), ferr_cnt - base_ferr, tbl[k].exp_ferr);
      check($sformatf("v%0d_ovr", k), ovr_cnt - base_ovr, 0);
      check($sformatf("v%0d_peak", k), peak, tbl[k].exp_pops);
      check($sformatf("v%0d_cnt", k), int'(fifo_cnt), 0);
      if (k == 0)
        check($sformatf("latency_%0d_within_%0d", rise_pc - drive_pc, LAT_MAX),
              int'(rise_pc - drive_pc <= LAT_MAX), 1);
    end

    // Random frames, random consumer back-pressure, checked against an in-order byte queue.
    base_q = got_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
    exp_ferr  = 0;
    rand_mode = 1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          d = 8'($urandom_range(0, 255));
          s = ($urandom_range(0, 4) != 0);
          send(d, s, -1);
          if (s) exp_q.push_back(d);
          else   exp_ferr++;
          $display("rand %0d: data 0x%02h stop %0d", k, d, s);
          line(1'b1, s ? int'($urandom_range(0, B)) : B + int'($urandom_range(0, B)));
        end
        line(1'b1, 2 * B);
        rand_mode = 0;
      end
      begin
        while (rand_mode != 0) begin
          @(posedge clk);
          #1;
          rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rx_ready = 1'b1;
    check("rand_pops", got_q.size() - base_q, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base_q + i < got_q.size())
        check($sformatf("rand_data%0d", i), int'(got_q[base_q + i]), int'(exp_q[i]));
    check("rand_ferr", ferr_cnt - base_ferr, exp_ferr);
    check("rand_ovr", ovr_cnt - base_ovr, 0);

    // Back-to-back frames into a stalled consumer: the FIFO fills, the extra byte is dropped.
    rx_ready = 1'b0;
    exp_q.delete();
    base_q = got_q.size(); base_ferr = ferr_cnt; base_ovr = ovr_cnt;
    mark++;
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b1, -1);
      exp_q.push_back(8'(k));
    end
    line(1'b1, B);
    $display("overrun: sent %0d frames, fifo_cnt %0d, overrun pulses %0d", exp_q.size(), fifo_cnt, ovr_cnt - base_ovr);
    check("ovr_cnt_full", int'(fifo_cnt), DEPTH);
    check("ovr_pulses", ovr_cnt - base_ovr, exp_q.size() - DEPTH);
    check("ovr_peak", peak, DEPTH);
    check("ovr_ferr", ferr_cnt - base_ferr, 0);
    check("ovr_no_pops", got_q.size() - base_q, 0);
    rx_ready = 1'b1;
    line(1'b1, 2 * DEPTH + 4);
    check("drain_pops", got_q.size() - base_q, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (base_q + i < got_q.size())
        check($sformatf("drain_data%0d", i), int'(got_q[base_q + i]), int'(exp_q[i]));
    @(negedge clk);
    check("drain_valid", int'(rx_valid), 0);

    // Reset in the middle of a frame with a byte already buffered.
    rx_ready = 1'b0;
    send(8'h11, 1'b1, -1);
    line(1'b1, B);
    check("pre_rst_cnt", int'(fifo_cnt), 1);
    line(1'b0, B);
    for (int i = 0; i < 4; i++) line(1'b1, B);
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_outputs", int'({rx_valid, rx_data, frame_err, overrun, fifo_cnt}), 0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    base_q = got_q.size(); base_ferr = ferr_cnt;
    mark++;
    line(1'b1, B);
    send(8'h5A, 1'b1, -1);
    line(1'b1, 2 * B);
    $display("post-reset: %0d byte(s), peak fifo_cnt %0d", got_q.size() - base_q, peak);
    check("post_rst_pops", got_q.size() - base_q, 1);
    if (got_q.size() > base_q) check("post_rst_data", int'(got_q[base_q]), 8'h5A);
    check("post_rst_peak", peak, 1);
    check("post_rst_cnt", int'(fifo_cnt), 0);
    check("post_rst_ferr", ferr_cnt - base_ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
